// File: rtl/fpu_shift_pkg.sv
// Shared types and constants for the FPU mantissa shift sequencer.
package fpu_shift_pkg;

    localparam int unsigned SHIFT_DATA_W   = 64;
    localparam int unsigned SHIFT_STEP_MAX = 7;
    localparam int unsigned SHIFT_AMT_W    = 7;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } shift_state_e;

endpackage

// File: rtl/fpu_shift_sequencer_if.sv
// Request/result bundle between the FPU microsequencer (master) and the
// shift sequencer (slave).
interface fpu_shift_sequencer_if;
    import fpu_shift_pkg::*;

    logic                    flush;
    logic                    start_valid;
    logic                    start_ready;
    logic [SHIFT_DATA_W-1:0] data_in;
    logic                    shift_left;
    logic [SHIFT_AMT_W-1:0]  shift_amount;
    logic                    result_valid;
    logic                    result_ready;
    logic [SHIFT_DATA_W-1:0] data_out;
    logic                    sticky;
    logic                    busy;

    modport master (
        output flush, start_valid, data_in, shift_left, shift_amount, result_ready,
        input  start_ready, result_valid, data_out, sticky, busy
    );

    modport slave (
        input  flush, start_valid, data_in, shift_left, shift_amount, result_ready,
        output start_ready, result_valid, data_out, sticky, busy
    );

endinterface

// File: rtl/fpu_shift_step.sv
// Single-cycle 0-7 bit zero-fill shift stage with right-shift sticky.
// Sticky OR logic exists only when FPU_SHIFT_STICKY_EN is defined.
module fpu_shift_step
    import fpu_shift_pkg::*;
(
    input  logic [SHIFT_DATA_W-1:0] data_i,
    input  logic [2:0]              step_i,
    input  logic                    left_i,
    output logic [SHIFT_DATA_W-1:0] data_o,
    output logic                    sticky_o
);

    always_comb begin
        data_o = left_i ? (data_i << step_i) : (data_i >> step_i);
    end

`ifdef FPU_SHIFT_STICKY_EN
    localparam logic [SHIFT_DATA_W-1:0] ALL_ONES = '1;
    logic [SHIFT_DATA_W-1:0] lost_mask;

    assign lost_mask = ~(ALL_ONES << step_i);
    assign sticky_o  = !left_i && (|(data_i & lost_mask));
`else
    assign sticky_o = 1'b0;
`endif

endmodule

// File: rtl/fpu_shift_sequencer.sv
// Multi-cycle barrel-shift controller: consumes a 0-127 bit distance in
// steps of up to 7 bits. Optional sticky collection via FPU_SHIFT_STICKY_EN.
module fpu_shift_sequencer
    import fpu_shift_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    fpu_shift_sequencer_if.slave  bus
);

    shift_state_e            state_q, state_d;
    logic [SHIFT_DATA_W-1:0] data_q, data_d;
    logic [SHIFT_AMT_W-1:0]  rem_q, rem_d;
    logic                    left_q, left_d;
    logic [2:0]              step;
    logic [SHIFT_DATA_W-1:0] step_data;
    logic                    step_sticky;
`ifdef FPU_SHIFT_STICKY_EN
    logic                    sticky_q, sticky_d;
`endif

    always_comb begin
        step = (rem_q > SHIFT_AMT_W'(SHIFT_STEP_MAX)) ? 3'(SHIFT_STEP_MAX) : rem_q[2:0];
    end

    fpu_shift_step u_step (
        .data_i   (data_q),
        .step_i   (step),
        .left_i   (left_q),
        .data_o   (step_data),
        .sticky_o (step_sticky)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        left_d  = left_q;
`ifdef FPU_SHIFT_STICKY_EN
        sticky_d = sticky_q;
`endif
        if (bus.flush) begin
            state_d = IDLE;
            rem_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_valid) begin
                        left_d = bus.shift_left;
                        rem_d  = '0;
`ifdef FPU_SHIFT_STICKY_EN
                        sticky_d = 1'b0;
`endif
                        if (bus.shift_amount == '0) begin
                            data_d  = bus.data_in;
                            state_d = DONE;
                        end else if (bus.shift_amount[SHIFT_AMT_W-1]) begin
                            // Whole operand shifted out in one go
                            data_d  = '0;
                            state_d = DONE;
`ifdef FPU_SHIFT_STICKY_EN
                            sticky_d = !bus.shift_left && (|bus.data_in);
`endif
                        end else begin
                            data_d  = bus.data_in;
                            rem_d   = bus.shift_amount;
                            state_d = SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    data_d = step_data;
                    rem_d  = rem_q - SHIFT_AMT_W'(step);
`ifdef FPU_SHIFT_STICKY_EN
                    sticky_d = sticky_q | step_sticky;
`endif
                    if (rem_d == '0) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (bus.result_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            left_q  <= 1'b0;
`ifdef FPU_SHIFT_STICKY_EN
            sticky_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            left_q  <= left_d;
`ifdef FPU_SHIFT_STICKY_EN
            sticky_q <= sticky_d;
`endif
        end
    end

    assign bus.start_ready  = (state_q == IDLE) && !bus.flush;
    assign bus.result_valid = (state_q == DONE);
    assign bus.busy         = (state_q != IDLE);
    assign bus.data_out     = data_q;
`ifdef FPU_SHIFT_STICKY_EN
    assign bus.sticky       = sticky_q;
`else
    // Step stage drives a constant 0 in this build
    assign bus.sticky       = step_sticky;
`endif

endmodule

// File: tb/tb_fpu_shift_sequencer.sv
// Self-checking bench for fpu_shift_sequencer: directed vectors with literal
// expectations plus a per-cycle comparison against a latency/result model.
module tb_fpu_shift_sequencer;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;
    bit   chk_en  = 1'b0;

    fpu_shift_sequencer_if bus ();

    fpu_shift_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic exp_st(input logic s);
`ifdef FPU_SHIFT_STICKY_EN
        return s;
`else
        return 1'b0;
`endif
    endfunction

    // Model: phase 0 idle, 1 shifting, 2 result held; result computed directly.
    int          m_phase = 0;
    int          m_cnt   = 0;
    logic [63:0] m_data  = '0;
    logic        m_sticky = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase = 0;
            m_cnt   = 0;
        end else if (bus.flush) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (bus.start_valid) begin
                    int n;
                    n = int'(bus.shift_amount);
                    if (n == 0) begin
                        m_data = bus.data_in; m_sticky = 1'b0;
                    end else if (n >= 64) begin
                        m_data = '0; m_sticky = !bus.shift_left && (bus.data_in != 0);
                    end else if (bus.shift_left) begin
                        m_data = bus.data_in << n; m_sticky = 1'b0;
                    end else begin
                        m_data = bus.data_in >> n;
                        m_sticky = (bus.data_in & ((64'h1 << n) - 64'h1)) != 0;
                    end
                    m_sticky = exp_st(m_sticky);
                    if (n == 0 || n >= 64) m_phase = 2;
                    else begin
                        m_phase = 1;
                        m_cnt   = (n + 6) / 7;
                    end
                end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) m_phase = 2;
                end
                2: if (bus.result_ready) m_phase = 0;
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en && reset_n) begin
            chk("model start_ready", bus.start_ready, (m_phase == 0) && !bus.flush);
            chk("model busy", bus.busy, m_phase != 0);
            chk("model result_valid", bus.result_valid, m_phase == 2);
            if (m_phase == 2) begin
                chk("model data_out", bus.data_out, m_data);
                chk("model sticky", bus.sticky, m_sticky);
            end
        end
    end

    task automatic do_req(input string nm, input logic [63:0] d, input logic l,
                          input logic [6:0] a, input logic [63:0] ed, input logic es,
                          input int elat);
        int lat;
        bus.start_valid = 1'b1; bus.data_in = d; bus.shift_left = l; bus.shift_amount = a;
        @(posedge clk); #2;
        bus.start_valid = 1'b0; bus.data_in = '0;
        lat = 1;
        while (!bus.result_valid && lat < 40) begin
            @(posedge clk); #2;
            lat++;
        end
        chk({nm, " latency"}, 64'(lat), 64'(elat));
        chk({nm, " data"}, bus.data_out, ed);
        chk({nm, " sticky"}, bus.sticky, exp_st(es));
        if (bus.result_ready) begin
            @(posedge clk); #2;
            chk({nm, " back to idle"}, bus.busy, 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        bus.flush = 1'b0; bus.start_valid = 1'b0; bus.data_in = '0;
        bus.shift_left = 1'b0; bus.shift_amount = '0; bus.result_ready = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        chk("reset data_out", bus.data_out, 0);
        chk("reset sticky", bus.sticky, 0);
        chk("reset result_valid", bus.result_valid, 0);
        chk("reset busy", bus.busy, 0);
        chk("reset start_ready", bus.start_ready, 1);
        @(posedge clk); @(posedge clk); #2;
        reset_n = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #2;

        do_req("r3",    64'h8000_0000_0000_0001, 1'b0, 7'd3,   64'h1000_0000_0000_0000, 1'b1, 2);
        do_req("l20",   64'h0000_0000_0000_00FF, 1'b1, 7'd20,  64'h0000_0000_0FF0_0000, 1'b0, 4);
        do_req("r63",   64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 7'd63,  64'h0000_0000_0000_0001, 1'b1, 10);
        do_req("r100",  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 7'd100, 64'h0,                   1'b1, 1);
        do_req("r0",    64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 7'd0,   64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1);
        do_req("r7",    64'h0000_0000_0000_0080, 1'b0, 7'd7,   64'h0000_0000_0000_0001, 1'b0, 2);
        do_req("l64",   64'h0000_0000_0000_0001, 1'b1, 7'd64,  64'h0,                   1'b0, 1);
        do_req("r8",    64'h0000_0000_0000_00F0, 1'b0, 7'd8,   64'h0,                   1'b1, 3);
        do_req("l63",   64'h8000_0000_0000_0001, 1'b1, 7'd63,  64'h8000_0000_0000_0000, 1'b0, 10);

        // Consumer stalls for 5 cycles; a request in that window must be ignored.
        bus.result_ready = 1'b0;
        do_req("hold", 64'h0000_0000_0000_00F1, 1'b1, 7'd5, 64'h0000_0000_0000_1E20, 1'b0, 2);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                bus.start_valid = 1'b1; bus.data_in = 64'hDEAD; bus.shift_amount = 7'd3;
            end
            chk("hold result_valid", bus.result_valid, 1);
            chk("hold data_out", bus.data_out, 64'h1E20);
            chk("hold start_ready", bus.start_ready, 0);
            @(posedge clk); #2;
            bus.start_valid = 1'b0;
        end
        bus.result_ready = 1'b1;
        @(posedge clk); #2;
        chk("hold release busy", bus.busy, 0);
        chk("hold release data_out", bus.data_out, 64'h1E20);

        // Flush in the second SHIFT cycle of a 50-bit shift, with a request pending.
        bus.start_valid = 1'b1; bus.data_in = 64'hFFFF_0000_FFFF_0000;
        bus.shift_left = 1'b0; bus.shift_amount = 7'd50;
        @(posedge clk); #2;
        bus.start_valid = 1'b0;
        @(posedge clk); #2;
        bus.flush = 1'b1; bus.start_valid = 1'b1;
        bus.data_in = 64'h0123_4567_89AB_CDEF; bus.shift_left = 1'b1; bus.shift_amount = 7'd4;
        #1;
        chk("flush start_ready", bus.start_ready, 0);
        chk("flush busy before edge", bus.busy, 1);
        @(posedge clk); #2;
        chk("flush idle", bus.busy, 0);
        chk("flush no result", bus.result_valid, 0);
        bus.flush = 1'b0;
        #1;
        chk("post-flush start_ready", bus.start_ready, 1);
        @(posedge clk); #2;
        bus.start_valid = 1'b0;
        chk("post-flush accepted", bus.busy, 1);
        lat = 1;
        while (!bus.result_valid && lat < 40) begin
            @(posedge clk); #2;
            lat++;
        end
        chk("post-flush latency", 64'(lat), 64'd2);
        chk("post-flush data", bus.data_out, 64'h1234_5678_9ABC_DEF0);
        @(posedge clk); #2;

        // Asynchronous reset in the middle of a shift.
        bus.start_valid = 1'b1; bus.data_in = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.shift_left = 1'b0; bus.shift_amount = 7'd63;
        @(posedge clk); #2;
        bus.start_valid = 1'b0;
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("async reset data_out", bus.data_out, 0);
        chk("async reset sticky", bus.sticky, 0);
        chk("async reset busy", bus.busy, 0);
        chk("async reset result_valid", bus.result_valid, 0);
        @(posedge clk); #2;
        reset_n = 1'b1;
        @(posedge clk); #2;
        do_req("after reset", 64'h8000_0000_0000_0001, 1'b0, 7'd3, 64'h1000_0000_0000_0000, 1'b1, 2);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fpu_shift_sequencer.md
# fpu_shift_sequencer

Multi-cycle barrel-shift controller for the FPU mantissa datapath. Accepts a 64-bit operand and a shift distance of 0-127 in either direction, then drives a single-cycle 0-7-bit shift step repeatedly until the full distance is consumed. Right shifts optionally collect a sticky bit for rounding. It sits between the FPU microsequencer (alignment and normalization requests) and the narrow mux-based shift stage.

## Interface
- No parameters; data width fixed at 64, step width fixed at 7.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous abort; returns the block to IDLE.
- `start_valid` in 1: request present.
- `start_ready` out 1: block can accept a request.
- `data_in` in 64: operand.
- `shift_left` in 1: 1 = left (toward MSB), 0 = right.
- `shift_amount` in 7: distance, 0-127.
- `result_valid` out 1: result held on `data_out`/`sticky`.
- `result_ready` in 1: consumer accepts result.
- `data_out` out 64: shifted operand.
- `sticky` out 1: OR of all bits shifted out on a right shift.
- `busy` out 1: state != IDLE.

## Operation
- States: IDLE, SHIFT, DONE.
- `start_ready` = (state == IDLE) && !`flush`. A request is accepted when `start_valid` && `start_ready`; it captures `data_in`, direction and amount, and clears sticky.
- Accept with amount 0: go to DONE; data unchanged; sticky = 0.
- Accept with amount >= 64: go to DONE; data = 0.
  - Right shift: sticky = |`data_in`.
  - Left shift: sticky = 0.
- Accept with amount 1-63: go to SHIFT with remaining = amount.
- SHIFT, each cycle:
  - step = min(remaining, 7); shift the data register by step, zero-filling.
  - Right shift: sticky |= OR of the step bits shifted out.
  - remaining -= step; when the new remaining is 0, go to DONE.
- DONE: `result_valid` = 1 and outputs are held stable. When `result_ready` is high, go to IDLE. No new request is accepted in the same cycle.
- `flush` in any state: go to IDLE next edge, `result_valid` drops, and any in-flight data is discarded. `flush` has priority over `start_valid` and over `result_ready`.
- Left-shift sticky is always 0; bits lost off the MSB are discarded.

## Timing
- Reset values: state IDLE; `data_out` = 0, `sticky` = 0, `result_valid` = 0, `busy` = 0, `start_ready` = 1 (when `flush` is low); remaining = 0.
- Reset asserted mid-operation aborts immediately and asynchronously; no result is produced.
- Latency from the accept edge to `result_valid` high:
  - amounts 0 and >= 64: 1 cycle;
  - amounts 1-63: ceil(n/7) + 1 cycles (for example, 7 → 2, 8 → 3, 63 → 10).
- Throughput: one request per latency + 1 cycles when `result_ready` is tied high.
- `data_out` and `sticky` change only in SHIFT, on accept, or on reset.
- `result_valid` stays high until `result_ready` or `flush`.

## Configuration
- `FPU_SHIFT_STICKY_EN` defined: sticky accumulation is implemented as described above.
- `FPU_SHIFT_STICKY_EN` undefined: `sticky` is tied to 0, and the sticky register and OR logic are removed. All other behaviour and latency are unchanged.

## Structure
- Shared package `fpu_shift_pkg`:
  - state enum (IDLE, SHIFT, DONE);
  - constants SHIFT_DATA_W = 64, SHIFT_STEP_MAX = 7, SHIFT_AMT_W = 7.
- Sub-module `fpu_shift_step`:
  - purely combinational;
  - inputs: 64-bit data, 3-bit step, direction;
  - outputs: shifted data and step-sticky (OR of the bits dropped on a right shift).
- The controller instantiates exactly one `fpu_shift_step`; the rest of the RTL is the FSM, remaining counter, and data/sticky registers.

## Test plan
- Right shift, `data_in` = 0x8000_0000_0000_0001, amount 3 → `result_valid` 2 cycles after accept, `data_out` = 0x1000_0000_0000_0000, `sticky` = 1.
- Left shift, `data_in` = 0x0000_0000_0000_00FF, amount 20 → 4 cycles, `data_out` = 0x0000_0000_0FF0_0000, `sticky` = 0.
- Right shift, `data_in` = 0xFFFF_FFFF_FFFF_FFFF, amount 63 → 10 cycles, `data_out` = 0x1, `sticky` = 1; amount 100 → 1 cycle, `data_out` = 0, `sticky` = 1; amount 0 → 1 cycle, `data_out` = `data_in`, `sticky` = 0.
- Hold `result_ready` low for 5 cycles → outputs stable and `start_ready` = 0 throughout; the `start_valid` pulse in that window is ignored. Raise `result_ready` → IDLE next cycle.
- Assert `flush` in SHIFT cycle 2 of a 50-bit shift with `start_valid` high → IDLE, no `result_valid`, no accept that cycle. Drop `flush` → request accepted on the next cycle.
- Assert `reset_n` low during SHIFT → all outputs 0 immediately. Repeat the sticky test with `FPU_SHIFT_STICKY_EN` undefined → `sticky` = 0 and `data_out` identical.
